// File: rtl/serial_logic_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : logic_pkg
// Description : Shared types for the bitwise logic blocks (parallel gate,
//               serial logic unit, future variants). Holds the operation
//               encoding and the serial unit's state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_pkg;

  // Operation code shared by every logic block.
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;

  // Serial unit control states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage : logic_pkg
`default_nettype wire

// File: rtl/serial_logic_unit_if.sv
`default_nettype none
// ============================================================================
// Interface   : serial_logic_unit_if
// Description : Operand/result handshake bundle for serial_logic_unit.
//   in_valid/in_ready + x, y, op : operation request channel
//   out_valid/out_ready + z      : result channel
//   busy                         : unit is shifting or holding a result
//   master modport : requester side (testbench / upstream logic)
//   slave modport  : the serial logic unit itself
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_logic_unit_if #(
  parameter int WIDTH = 4
);
  import logic_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  op_t              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             busy;

  modport master (
    output in_valid, x, y, op, out_ready,
    input  in_ready, out_valid, z, busy
  );

  modport slave (
    input  in_valid, x, y, op, out_ready,
    output in_ready, out_valid, z, busy
  );

endinterface : serial_logic_unit_if
`default_nettype wire

// File: rtl/serial_logic_unit_cell.sv
`default_nettype none
// ============================================================================
// Module      : bit_logic_cell
// Description : Purely combinational 1-bit logic evaluator.
//   a, b : operand bits
//   op   : operation select (AND / OR / XOR / NAND)
//   r    : result bit
// Revision    : 1.0 - initial release
// ============================================================================
module bit_logic_cell
  import logic_pkg::*;
(
  input  logic a,
  input  logic b,
  input  op_t  op,
  output logic r
);

  always_comb begin
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = 1'b0;
    endcase
  end

endmodule : bit_logic_cell
`default_nettype wire

// File: rtl/serial_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : serial_logic_unit
// Description : Bit-serial bitwise logic unit. Captures two WIDTH-bit
//               operands and an op, evaluates one bit per clock (LSB first)
//               through a single bit_logic_cell, then presents the result
//               until the downstream handshake completes.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_logic_unit_if slave (request, result, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_logic_unit
  import logic_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_logic_unit_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [WIDTH-1:0] zs_q, zs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d;
  logic             cell_r;

  bit_logic_cell u_cell (
    .a  (xs_q[0]),
    .b  (ys_q[0]),
    .op (op_q),
    .r  (cell_r)
  );

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    zs_d    = zs_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          xs_d    = bus.x;
          ys_d    = bus.y;
          op_d    = bus.op;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // New bit enters at the MSB so after WIDTH shifts bit 0 lines up.
        zs_d = {cell_r, zs_q[WIDTH-1:1]};
        xs_d = xs_q >> 1;
        ys_d = ys_q >> 1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        // The release cycle never accepts; a new request waits for IDLE.
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      zs_q    <= '0;
      cnt_q   <= '0;
      op_q    <= OP_AND;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      zs_q    <= zs_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.z         = zs_q;

endmodule : serial_logic_unit
`default_nettype wire

// File: tb/tb_serial_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_logic_unit
// Description : Self-checking bench for serial_logic_unit (WIDTH=4 and 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_logic_unit;
  import logic_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errs;

  serial_logic_unit_if #(.WIDTH(4)) bus4 ();
  serial_logic_unit_if #(.WIDTH(8)) bus8 ();

  serial_logic_unit #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  serial_logic_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    op_t        op;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the 4-bit unit, with latency and handshake checks.
  task automatic run4(input logic [3:0] x, input logic [3:0] y, input op_t op,
                      input logic [3:0] exp, input string name);
    int n;
    chk({name, "_in_ready_idle"}, 32'(bus4.in_ready), 32'd1);
    bus4.x = x; bus4.y = y; bus4.op = op; bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    bus4.x = ~x; bus4.y = ~y; bus4.op = OP_XOR;
    chk({name, "_in_ready_shift"}, 32'(bus4.in_ready), 32'd0);
    n = 0;
    while (!bus4.out_valid && n < 20) begin
      step();
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd4);
    chk({name, "_z"}, 32'(bus4.z), 32'(exp));
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    chk({name, "_released"}, 32'({bus4.out_valid, bus4.in_ready}), 32'b01);
    chk({name, "_z_kept"}, 32'(bus4.z), 32'(exp));
  endtask

  initial begin
    int n;
    int k;
    int acc2;
    int res1_k;
    logic seen_valid;
    logic prev_busy;
    logic [3:0] res1;

    checks = 0;
    errs   = 0;
    vecs[0] = '{4'hA, 4'h6, OP_AND,  4'h2};
    vecs[1] = '{4'hC, 4'hA, OP_AND,  4'h8};
    vecs[2] = '{4'hC, 4'hA, OP_OR,   4'hE};
    vecs[3] = '{4'hC, 4'hA, OP_XOR,  4'h6};
    vecs[4] = '{4'hC, 4'hA, OP_NAND, 4'h7};
    vecs[5] = '{4'hF, 4'hF, OP_NAND, 4'h0};
    vecs[6] = '{4'h0, 4'h0, OP_NAND, 4'hF};
    vecs[7] = '{4'h9, 4'h3, OP_XOR,  4'hA};

    bus4.in_valid = 0; bus4.x = 0; bus4.y = 0; bus4.op = OP_AND; bus4.out_ready = 0;
    bus8.in_valid = 0; bus8.x = 0; bus8.y = 0; bus8.op = OP_AND; bus8.out_ready = 0;
    rst_n = 1'b0;
    step();
    step();
    chk("reset_outputs", 32'({bus4.in_ready, bus4.out_valid, bus4.busy, bus4.z}), 32'h40);
    rst_n = 1'b1;
    step();

    // Main function over the vector table.
    foreach (vecs[i]) run4(vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));

    // Reset asserted mid-SHIFT aborts the operation.
    bus4.x = 4'hA; bus4.y = 4'h6; bus4.op = OP_AND; bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_shift", 32'({bus4.in_ready, bus4.out_valid, bus4.busy, bus4.z}), 32'h40);
    #3 rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus4.out_valid) seen_valid = 1'b1;
    end
    chk("rst_no_result", 32'(seen_valid), 32'd0);

    // Backpressure: DONE held, in_valid pulse ignored.
    bus4.x = 4'hC; bus4.y = 4'hA; bus4.op = OP_XOR; bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    n = 0;
    while (!bus4.out_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp_latency", 32'(n), 32'd4);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus4.x = 4'h5; bus4.y = 4'h5; bus4.op = OP_NAND; bus4.in_valid = 1'b1;
      end else begin
        bus4.in_valid = 1'b0;
      end
      step();
      chk("bp_hold", 32'({bus4.out_valid, bus4.in_ready, bus4.z}), 32'h26);
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus4.out_valid || bus4.busy) seen_valid = 1'b1;
      step();
    end
    chk("bp_single_handshake", 32'({seen_valid, bus4.in_ready, bus4.z}), 32'h16);

    // Back-to-back with in_valid held and out_ready high.
    bus4.x = 4'hC; bus4.y = 4'hA; bus4.op = OP_OR; bus4.in_valid = 1'b1;
    bus4.out_ready = 1'b1;
    step();
    bus4.x = 4'hA; bus4.y = 4'h6; bus4.op = OP_AND;
    prev_busy = bus4.busy;
    acc2 = -1; res1_k = -1; res1 = 4'h0;
    for (k = 1; k <= 20 && acc2 < 0; k++) begin
      if (bus4.out_valid && res1_k < 0) begin
        res1_k = k - 1;
        res1 = bus4.z;
      end
      step();
      if (bus4.busy && !prev_busy) acc2 = k;
      prev_busy = bus4.busy;
    end
    bus4.in_valid = 1'b0;
    chk("b2b_first_latency", 32'(res1_k), 32'd4);
    chk("b2b_first_z", 32'(res1), 32'hE);
    chk("b2b_second_accept", 32'(acc2), 32'd6);
    n = 0;
    while (!bus4.out_valid && n < 20) begin
      step();
      n++;
    end
    chk("b2b_second_latency", 32'(n), 32'd4);
    chk("b2b_second_z", 32'(bus4.z), 32'h2);
    step();
    bus4.out_ready = 1'b0;

    // WIDTH=8 build.
    bus8.x = 8'hF0; bus8.y = 8'h3C; bus8.op = OP_XOR; bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    n = 0;
    while (!bus8.out_valid && n < 40) begin
      step();
      n++;
    end
    chk("w8_latency", 32'(n), 32'd8);
    chk("w8_z", 32'(bus8.z), 32'hCC);
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    chk("w8_released", 32'({bus8.out_valid, bus8.in_ready}), 32'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule : tb_serial_logic_unit
`default_nettype wire
